// File: rtl/restoring_divider_unsigned.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider_unsigned
// Purpose  : Sequential unsigned divider using the restoring shift-subtract
//            algorithm. It produces one quotient bit per enabled clock, so
//            the latency is DIV_NUM_BITS enabled cycles.
// Ports    :
//   tb_clk          clock, rising edge
//   tb_srst         asynchronous active-low reset
//   CE              clock enable; when low, every register holds
//   start           launch request (accepted in IDLE/DONE only)
//   NUMERATOR_IN    dividend, sampled on the accepting edge
//   DENOMINATOR_IN  divisor, sampled on the accepting edge
//   QUOTENT_OUT     quotient, registered, updated on completion only
//   REMAINDER_OUT   remainder, registered, updated on completion only
//   done            result valid; held until the next accepted start
//   error           divide-by-zero flag for the last operation
// Options  : define DIV_ZERO_FAST_EN to finish a divide-by-zero one enabled
//            cycle after start instead of running all iterations.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_divider_unsigned #(
    parameter int DIV_NUM_BITS = 8,
    parameter int DIV_DEN_BITS = 8
) (
    input  logic                    tb_clk,
    input  logic                    tb_srst,
    input  logic                    CE,
    input  logic [DIV_NUM_BITS-1:0] NUMERATOR_IN,
    input  logic [DIV_DEN_BITS-1:0] DENOMINATOR_IN,
    output logic [DIV_NUM_BITS-1:0] QUOTENT_OUT,
    output logic [DIV_DEN_BITS-1:0] REMAINDER_OUT,
    input  logic                    start,
    output logic                    error,
    output logic                    done
);

    localparam int CNT_W = $clog2(DIV_NUM_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;

    // num_sh starts as the dividend; quotient bits fill it from the LSB as
    // dividend bits leave from the MSB.
    logic [DIV_NUM_BITS-1:0] num_sh;
    logic [DIV_DEN_BITS-1:0] den_reg;
    // After every restore the partial remainder is below the divisor, so only
    // DIV_DEN_BITS bits need storing; the extra bit exists in the trial value.
    logic [DIV_DEN_BITS-1:0] rem;
    logic [CNT_W-1:0]        cnt;

    logic                    accept;
    logic                    last_iter;
    logic                    q_bit;
    logic                    zero_short;
    logic                    den_in_zero;
    logic [DIV_DEN_BITS:0]   trial;
    logic [DIV_DEN_BITS-1:0] rem_next;
    logic [DIV_NUM_BITS-1:0] quot_next;
    logic [DIV_NUM_BITS-1:0] quot_final;
    logic [DIV_DEN_BITS-1:0] rem_final;

    always_comb begin
        accept      = CE && start && (state != BUSY);
        last_iter   = (cnt == CNT_W'(1));
        den_in_zero = (DENOMINATOR_IN == '0);

        // Shift the next dividend bit into the partial remainder.
        trial = {rem, num_sh[DIV_NUM_BITS-1]};
        q_bit = (trial >= {1'b0, den_reg});
        // When the subtraction succeeds the difference is below den_reg, so
        // it is exact in DIV_DEN_BITS bits even though trial has one more.
        rem_next  = q_bit ? (trial[DIV_DEN_BITS-1:0] - den_reg)
                          : trial[DIV_DEN_BITS-1:0];
        quot_next = {num_sh[DIV_NUM_BITS-2:0], q_bit};

`ifdef DIV_ZERO_FAST_EN
        // Short divide-by-zero: num_sh still holds the untouched dividend,
        // so the values the full algorithm would reach are formed directly.
        zero_short = (den_reg == '0);
`else
        zero_short = 1'b0;
`endif
        quot_final = zero_short ? '1 : quot_next;
        rem_final  = zero_short ? DIV_DEN_BITS'(num_sh) : rem_next;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge tb_clk or negedge tb_srst) begin
        if (!tb_srst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (CE && last_iter) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge tb_clk or negedge tb_srst) begin
        if (!tb_srst) begin
            num_sh        <= '0;
            den_reg       <= '0;
            rem           <= '0;
            cnt           <= '0;
            QUOTENT_OUT   <= '0;
            REMAINDER_OUT <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else if (CE) begin
            if (accept) begin
                num_sh  <= NUMERATOR_IN;
                den_reg <= DENOMINATOR_IN;
                rem     <= '0;
`ifdef DIV_ZERO_FAST_EN
                cnt     <= den_in_zero ? CNT_W'(1) : CNT_W'(DIV_NUM_BITS);
`else
                cnt     <= den_in_zero ? CNT_W'(DIV_NUM_BITS) : CNT_W'(DIV_NUM_BITS);
`endif
                done    <= 1'b0;
                error   <= 1'b0;
            end else if (state == BUSY) begin
                num_sh <= quot_next;
                rem    <= rem_next;
                cnt    <= cnt - CNT_W'(1);
                if (last_iter) begin
                    QUOTENT_OUT   <= quot_final;
                    REMAINDER_OUT <= rem_final;
                    done          <= 1'b1;
                    error         <= (den_reg == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_unsigned.sv
`default_nettype none
// ============================================================================
// Module   : tb_restoring_divider_unsigned
// Purpose  : Self-checking bench for restoring_divider_unsigned (8/8 build).
//            A behavioural model predicts done/error/quotient/remainder from
//            plain division; a compare process checks every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider_unsigned;

    localparam int N = 8;
    localparam int D = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = N;
`endif

    logic         tb_clk = 1'b0;
    logic         tb_srst = 1'b0;
    logic         CE = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] NUMERATOR_IN = '0;
    logic [D-1:0] DENOMINATOR_IN = '0;
    logic [N-1:0] QUOTENT_OUT;
    logic [D-1:0] REMAINDER_OUT;
    logic         error;
    logic         done;

    restoring_divider_unsigned #(N, D) dut (
        .tb_clk         (tb_clk),
        .tb_srst        (tb_srst),
        .CE             (CE),
        .NUMERATOR_IN   (NUMERATOR_IN),
        .DENOMINATOR_IN (DENOMINATOR_IN),
        .QUOTENT_OUT    (QUOTENT_OUT),
        .REMAINDER_OUT  (REMAINDER_OUT),
        .start          (start),
        .error          (error),
        .done           (done)
    );

    always #5 tb_clk = ~tb_clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: remaining enabled edges until the pending result
    // becomes visible, and the result computed with plain / and %.
    // ------------------------------------------------------------------
    int           m_left;
    logic         m_done, m_err, p_err;
    logic [N-1:0] m_q, p_q;
    logic [D-1:0] m_r, p_r;

    always @(posedge tb_clk or negedge tb_srst) begin
        if (!tb_srst) begin
            m_left = 0; m_done = 0; m_err = 0; m_q = '0; m_r = '0;
        end else if (CE) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_err = p_err; m_q = p_q; m_r = p_r;
                end
            end else if (start) begin
                p_err = (DENOMINATOR_IN == 0);
                p_q   = p_err ? {N{1'b1}} : N'(int'(NUMERATOR_IN) / int'(DENOMINATOR_IN));
                p_r   = p_err ? D'(NUMERATOR_IN) : D'(int'(NUMERATOR_IN) % int'(DENOMINATOR_IN));
                m_done = 0; m_err = 0;
                m_left = p_err ? ZLAT : N;
            end
        end
    end

    bit cmp_on = 0;
    always @(negedge tb_clk) begin
        if (cmp_on) begin
            check("cyc_done",  32'(done),          32'(m_done));
            check("cyc_error", 32'(error),         32'(m_err));
            check("cyc_quot",  32'(QUOTENT_OUT),   32'(m_q));
            check("cyc_rem",   32'(REMAINDER_OUT), 32'(m_r));
        end
    end

    // Launch one operation and return the number of edges until done.
    task automatic run_op(input logic [N-1:0] n, input logic [D-1:0] d,
                          input bit stall, output int lat);
        bit stalled;
        stalled = 0;
        @(negedge tb_clk);
        NUMERATOR_IN = n; DENOMINATOR_IN = d; start = 1; CE = 1;
        @(posedge tb_clk);
        #1 start = 0;
        check("done_drop", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            if (stall && lat == 2 && !stalled) begin
                CE = 0;
                repeat (3) @(posedge tb_clk);
                #1 CE = 1;
                lat += 3;
                stalled = 1;
            end else begin
                @(posedge tb_clk);
                #1 lat++;
            end
        end
        check("op_timeout", 32'(done), 32'd1);
    endtask

    task automatic op_lit(input string name, input logic [N-1:0] n, input logic [D-1:0] d,
                          input bit stall, input int e_q, input int e_r, input int e_err,
                          input int e_lat);
        int lat;
        run_op(n, d, stall, lat);
        check({name, "_q"},   32'(QUOTENT_OUT),   32'(e_q));
        check({name, "_r"},   32'(REMAINDER_OUT), 32'(e_r));
        check({name, "_err"}, 32'(error),         32'(e_err));
        check({name, "_lat"}, 32'(lat),           32'(e_lat));
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge tb_clk);
        check("rst_q",    32'(QUOTENT_OUT),   32'd0);
        check("rst_r",    32'(REMAINDER_OUT), 32'd0);
        check("rst_done", 32'(done),          32'd0);
        check("rst_err",  32'(error),         32'd0);
        #2 tb_srst = 1;
        cmp_on = 1;

        op_lit("d200_7",   8'd200, 8'd7,   0, 28,  4,  0, 8);
        op_lit("d255_255", 8'd255, 8'd255, 0, 1,   0,  0, 8);
        op_lit("d0_255",   8'd0,   8'd255, 0, 0,   0,  0, 8);
        op_lit("d255_1",   8'd255, 8'd1,   0, 255, 0,  0, 8);
        op_lit("d5_200",   8'd5,   8'd200, 0, 0,   5,  0, 8);
        op_lit("d13_0",    8'd13,  8'd0,   0, 255, 13, 1, ZLAT);
        op_lit("d200_7s",  8'd200, 8'd7,   1, 28,  4,  0, 11);

        // Reset in the middle of an operation.
        @(negedge tb_clk);
        NUMERATOR_IN = 8'd77; DENOMINATOR_IN = 8'd3; start = 1; CE = 1;
        @(posedge tb_clk);
        #1 start = 0;
        repeat (3) @(posedge tb_clk);
        #2 tb_srst = 0;
        #1;
        check("arst_q",    32'(QUOTENT_OUT),   32'd0);
        check("arst_r",    32'(REMAINDER_OUT), 32'd0);
        check("arst_done", 32'(done),          32'd0);
        check("arst_err",  32'(error),         32'd0);
        start = 1;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        start = 0;
        #2 tb_srst = 1;
        op_lit("d100_9", 8'd100, 8'd9, 0, 11, 1, 0, 8);

        // Random traffic: start pulses of any length, CE gaps, zero divisors.
        repeat (4000) begin
            @(negedge tb_clk);
            start          = ($urandom % 4 == 0);
            CE             = ($urandom % 8 != 0);
            NUMERATOR_IN   = N'($urandom);
            DENOMINATOR_IN = ($urandom % 12 == 0) ? '0 : D'($urandom);
        end
        @(negedge tb_clk);
        start = 0; CE = 1;
        repeat (12) @(negedge tb_clk);
        op_lit("d9_4", 8'd9, 8'd4, 0, 2, 1, 0, 8);

        cmp_on = 0;
        @(negedge tb_clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
